mem_port_arbiter: RTL

- Shares one single-port data/instruction SRAM among three requesters:
  - the microcoded core's instruction fetch (I);
  - the core's load/store path (D);
  - an external debug/loader port (X).
- Sits between the core's iMem/dMem interfaces and the physical memory macro.
- Arbitrates, registers the winning request, and drives the SRAM for WAIT_STATES+1 cycles.
- Returns read data to the winner with a one-cycle valid pulse.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/rr_prio_select.sv | 17 +
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner/state types and byte-enable constant shared by the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWNER_I, OWNER_D, OWNER_X} owner_t;
  typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;
  localparam int BE_MAX_W = 128;
  localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = '1;
endpackage

// File: rtl/rr_prio_select.sv
// rr_prio_select: one-hot pick among I/D/X; X has priority, I/D alternate, lock admits only X
module rr_prio_select
  import mem_arb_pkg::*;
(
  input  logic       i_i_req,
  input  logic       i_d_req,
  input  logic       i_x_req,
  input  logic       i_lock,
  input  owner_t     i_rr_last,
  output logic [2:0] o_gnt
);
  logic w_id_ok;
  assign w_id_ok  = !i_lock && !i_x_req;
  assign o_gnt[2] = i_x_req;
  assign o_gnt[1] = w_id_ok && i_d_req && (!i_i_req || i_rr_last == OWNER_I);
  assign o_gnt[0] = w_id_ok && i_i_req && (!i_d_req || i_rr_last != OWNER_I);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between fetch, load/store and debug ports
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    iReq,
  input  logic [ADDR_WIDTH-1:0]   iAddr,
  output logic                    iGnt,
  output logic                    iRValid,
  output logic [DATA_WIDTH-1:0]   iRData,
  input  logic                    dReq,
  input  logic                    dWE,
  input  logic [DATA_WIDTH/8-1:0] dByteEn,
  input  logic [ADDR_WIDTH-1:0]   dAddr,
  input  logic [DATA_WIDTH-1:0]   dWData,
  output logic                    dGnt,
  output logic                    dRValid,
  output logic [DATA_WIDTH-1:0]   dRData,
  input  logic                    xReq,
  input  logic                    xWE,
  input  logic [DATA_WIDTH/8-1:0] xByteEn,
  input  logic [ADDR_WIDTH-1:0]   xAddr,
  input  logic [DATA_WIDTH-1:0]   xWData,
  input  logic                    xLock,
  output logic                    xGnt,
  output logic                    xRValid,
  output logic [DATA_WIDTH-1:0]   xRData,
  output logic                    memCE,
  output logic                    memWE,
  output logic [DATA_WIDTH/8-1:0] memByteEn,
  output logic [ADDR_WIDTH-1:0]   memAddr,
  output logic [DATA_WIDTH-1:0]   memWData,
  input  logic [DATA_WIDTH-1:0]   memRData,
  output logic                    locked
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  arb_state_t            r_state, w_state_nxt;
  logic [CW-1:0]         r_wait_cnt, w_wait_nxt;
  owner_t                r_rr_last, r_owner, w_owner;
  logic                  r_lock, r_we, w_last, w_can_grant, w_any_gnt, w_rd_done;
  logic [2:0]            w_sel, w_gnt, r_rvalid;
  logic [BW-1:0]         r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_i_rdata, r_d_rdata, r_x_rdata;

  rr_prio_select u_sel (
    .i_i_req  (iReq),
    .i_d_req  (dReq),
    .i_x_req  (xReq),
    .i_lock   (r_lock),
    .i_rr_last(r_rr_last),
    .o_gnt    (w_sel)
  );

  assign w_last      = r_state == ARB_ACCESS && r_wait_cnt == '0;
  assign w_can_grant = r_state == ARB_IDLE || w_last;
  assign w_gnt       = w_can_grant ? w_sel : 3'b000;
  assign w_any_gnt   = |w_gnt;
  assign w_owner     = w_gnt[2] ? OWNER_X : w_gnt[1] ? OWNER_D : OWNER_I;
  assign w_rd_done   = w_last && !r_we;

  always_comb begin
    w_state_nxt = w_any_gnt ? ARB_ACCESS : w_last ? ARB_IDLE : r_state;
    w_wait_nxt  = w_any_gnt ? CW'(WAIT_STATES) : (r_state == ARB_ACCESS && !w_last) ? r_wait_cnt - CW'(1) : r_wait_cnt;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= ARB_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rr_last <= OWNER_D;
      r_owner   <= OWNER_I;
      r_lock    <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_x_rdata <= '0;
    end else begin
      // read data is returned to the window's owner while the next window may already be granted
      r_rvalid  <= w_rd_done ? 3'b001 << r_owner : 3'b000;
      r_i_rdata <= (w_rd_done && r_owner == OWNER_I) ? memRData : r_i_rdata;
      r_d_rdata <= (w_rd_done && r_owner == OWNER_D) ? memRData : r_d_rdata;
      r_x_rdata <= (w_rd_done && r_owner == OWNER_X) ? memRData : r_x_rdata;
      r_lock    <= w_can_grant ? xLock && (r_lock || w_gnt[2]) : r_lock;
      if (w_any_gnt) begin
        r_owner <= w_owner;
        r_we    <= w_gnt[2] ? xWE : w_gnt[1] && dWE;
        r_be    <= w_gnt[2] ? xByteEn : w_gnt[1] ? dByteEn : BE_ALL_ONES[BW-1:0];
        r_addr  <= w_gnt[2] ? xAddr : w_gnt[1] ? dAddr : iAddr;
        r_wdata <= w_gnt[2] ? xWData : w_gnt[1] ? dWData : '0;
        if (!w_gnt[2]) r_rr_last <= w_owner;
      end
    end
  end

  assign iGnt      = w_gnt[0];
  assign dGnt      = w_gnt[1];
  assign xGnt      = w_gnt[2];
  assign iRValid   = r_rvalid[0];
  assign dRValid   = r_rvalid[1];
  assign xRValid   = r_rvalid[2];
  assign iRData    = r_i_rdata;
  assign dRData    = r_d_rdata;
  assign xRData    = r_x_rdata;
  assign memCE     = r_state == ARB_ACCESS;
  assign memWE     = memCE && r_we;
  assign memByteEn = r_be;
  assign memAddr   = r_addr;
  assign memWData  = r_wdata;
  assign locked    = r_lock;
endmodule
